// File: rtl/ex_lane_interlock.sv
// ---------------------------------------------------------------------------
// ex_lane_interlock
//
// Dual-lane execute interlock. Tracks the register IDs that are still being
// produced in EX1 (live, from the lanes) and EX2 (two registered scoreboard
// slots). A decode source that needs one of those IDs stalls decode. EX3
// results are forwarded, so no EX3 slot is kept. A small RUN/HOLD/FAULT
// machine counts consecutive EX holds and latches a sticky fault once a
// hold runs too long. Only reset leaves FAULT.
//
// Ports
//   clock                 rising-edge clock
//   reset                 asynchronous, active-high reset
//   exHoldA/B   [1:0]     lane EX1 {regHeld, exHold}
//   heldIdA/B   [5:0]     lane EX1 held destination ID
//   idRs/Rt/RmA [5:0]     lane A decode source IDs
//   idRs/Rt/RmB [5:0]     lane B decode source IDs
//   memHold               memory-stage hold
//   opBraFlush            branch flush of the EX1 contents
//   exStall               freezes EX1 and later stages
//   idStall               freezes decode and bubbles EX1
//   faultValid            sticky fault flag
//   faultLane   [1:0]     faulting lane(s): 01 = A, 10 = B, 11 = both
//   holdCount   [7:0]     consecutive hold cycle count
// ---------------------------------------------------------------------------
module ex_lane_interlock #(
  parameter logic [5:0] ZZR_ID     = 6'h3F,
  parameter int         HOLD_LIMIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] exHoldA,
  input  logic [1:0] exHoldB,
  input  logic [5:0] heldIdA,
  input  logic [5:0] heldIdB,
  input  logic [5:0] idRsA,
  input  logic [5:0] idRtA,
  input  logic [5:0] idRmA,
  input  logic [5:0] idRsB,
  input  logic [5:0] idRtB,
  input  logic [5:0] idRmB,
  input  logic       memHold,
  input  logic       opBraFlush,
  output logic       exStall,
  output logic       idStall,
  output logic       faultValid,
  output logic [1:0] faultLane,
  output logic [7:0] holdCount
);

  localparam logic [7:0] LIMIT_C  = 8'(HOLD_LIMIT);
  localparam logic [7:0] LIMIT_M1 = 8'(HOLD_LIMIT - 1);

  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_FAULT} state_e;

  state_e     state_q;
  logic [7:0] holdCount_q;
  logic       faultValid_q;
  logic [1:0] faultLane_q;

  logic       s2AVld_q, s2BVld_q;
  logic [5:0] s2AId_q, s2BId_q;
  logic       s2AVld_d, s2BVld_d;

  logic       heldVldA, heldVldB;
  logic       exHoldAny;
  logic       hazard;
  logic [5:0] srcId [6];

  // A held entry naming the null register never blocks anyone.
  assign heldVldA  = exHoldA[1] && (heldIdA != ZZR_ID);
  assign heldVldB  = exHoldB[1] && (heldIdB != ZZR_ID);
  assign exHoldAny = exHoldA[0] | exHoldB[0];

  always_comb begin
    srcId[0] = idRsA;
    srcId[1] = idRtA;
    srcId[2] = idRmA;
    srcId[3] = idRsB;
    srcId[4] = idRtB;
    srcId[5] = idRmB;
  end

  // Every source of both lanes against both EX1 entries and both EX2 slots.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (srcId[i] != ZZR_ID) begin
        if ((heldVldA && (srcId[i] == heldIdA)) ||
            (heldVldB && (srcId[i] == heldIdB)) ||
            (s2AVld_q && (srcId[i] == s2AId_q)) ||
            (s2BVld_q && (srcId[i] == s2BId_q)))
          hazard = 1'b1;
      end
    end
  end

  // Reset forces state_q to RUN asynchronously, so the FAULT term drops
  // immediately while the live hold inputs still pass through.
  assign exStall = exHoldAny | memHold | (state_q == ST_FAULT);
  assign idStall = exStall | hazard;

  // Flush wins over the EX1 entries; a stalled pipe keeps EX2 as is.
  always_comb begin
    s2AVld_d = s2AVld_q;
    s2BVld_d = s2BVld_q;
    if (!exStall) begin
      s2AVld_d = opBraFlush ? 1'b0 : heldVldA;
      s2BVld_d = opBraFlush ? 1'b0 : heldVldB;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2AVld_q <= 1'b0;
      s2BVld_q <= 1'b0;
    end else begin
      s2AVld_q <= s2AVld_d;
      s2BVld_q <= s2BVld_d;
    end
  end

  // IDs are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clock) begin
    if (!exStall) begin
      s2AId_q <= heldIdA;
      s2BId_q <= heldIdB;
    end
  end

  // Hold watchdog. memHold and opBraFlush deliberately play no part here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      holdCount_q  <= 8'd0;
      faultValid_q <= 1'b0;
      faultLane_q  <= 2'b00;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (exHoldAny) begin
            state_q     <= ST_HOLD;
            holdCount_q <= 8'd1;
          end else begin
            holdCount_q <= 8'd0;
          end
        end
        ST_HOLD: begin
          if (!exHoldAny) begin
            state_q     <= ST_RUN;
            holdCount_q <= 8'd0;
          end else if (holdCount_q == LIMIT_M1) begin
            state_q      <= ST_FAULT;
            holdCount_q  <= LIMIT_C;
            faultValid_q <= 1'b1;
            faultLane_q  <= {exHoldB[0], exHoldA[0]};
          end else begin
            holdCount_q <= holdCount_q + 8'd1;
          end
        end
        ST_FAULT: begin
          holdCount_q  <= LIMIT_C;
          faultValid_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_RUN;
          holdCount_q <= 8'd0;
        end
      endcase
    end
  end

  assign faultValid = faultValid_q;
  assign faultLane  = faultLane_q;
  assign holdCount  = holdCount_q;

endmodule
